// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types and widths for the divider and multiply-accumulator.
package calc_pkg;
  localparam int CALC_W = 4;
  localparam int CNT_W = $clog2(CALC_W);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/mul_add_par.sv
// mul_add_par: sequential MSB-first shift-and-add computing p = a*b + c over W cycles.
module mul_add_par
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic [2*W-1:0] p,
  output logic           valid,
  output logic           busy
);
  localparam int CW = $clog2(W);
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc;
  logic go;
  assign go = start && state != ITER;
  always_comb begin
    state_n = (state == ITER) ? ((cnt == '0) ? DONE : ITER) : (start ? ITER : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // The sum never exceeds 2^(2W) - 2^W, so a 2W-bit add cannot carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= CW'(W - 1);
    end else if (go) begin
      a_r <= a;
      b_r <= b;
      acc <= {{W{1'b0}}, c};
      cnt <= CW'(W - 1);
    end else if (state == ITER) begin
      if (a_r[cnt]) acc <= acc + ({{W{1'b0}}, b_r} << cnt);
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end
  assign p = acc;
  assign valid = state == DONE;
  assign busy = state == ITER;
endmodule

// File: tb/tb_mul_add_par.sv
// tb_mul_add_par: randomized self-checking bench for mul_add_par against p = a*b + c.
module tb_mul_add_par;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic [2*W-1:0] p;
  logic valid, busy;
  int checks = 0;
  int failures = 0;

  mul_add_par #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .p(p), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model(input int x, input int y, input int z);
    return x * y + z;
  endfunction

  task automatic run_op(input int ta, input int tb, input int tc,
                        output logic [2*W-1:0] rp, output int lat, output int bc);
    @(negedge clk);
    a = W'(ta); b = W'(tb); c = W'(tc); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    bc = busy ? 1 : 0;
    lat = 0;
    while (!valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
    rp = p;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (p !== 8'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: p=%0d valid=%b busy=%b required p=0 valid=0 busy=0", p, valid, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input int ta, input int tb, input int tc);
    logic [2*W-1:0] rp;
    int lat, bc;
    run_op(ta, tb, tc, rp, lat, bc);
    checks++;
    if (rp !== 8'(model(ta, tb, tc)) || lat != W || bc != W) begin
      failures++;
      $display("FAIL %s: p=%0d lat=%0d busy_cycles=%0d required p=%0d lat=%0d busy_cycles=%0d",
               name, rp, lat, bc, model(ta, tb, tc), W, W);
    end
  endtask

  task automatic test_basic;
    test_vector("basic", 3, 5, 2);
    test_vector("max", 15, 15, 15);
    test_vector("zero_a", 0, 9, 7);
    test_vector("zero_b", 9, 0, 0);
  endtask

  task automatic test_ignored_restart;
    int n;
    @(negedge clk);
    a = 4'd2; b = 4'd6; c = 4'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 4'd7; b = 4'd9; c = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b1; a = 4'd15; b = 4'd15; c = 4'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 2;
    while (!valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (p !== 8'd13 || n != W) begin
      failures++;
      $display("FAIL ignored_restart: p=%0d lat=%0d required p=13 lat=%0d", p, n, W);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || p !== 8'd13) begin
      failures++;
      $display("FAIL done_hold: p=%0d valid=%b required p=13 valid=1", p, valid);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 4'd15; b = 4'd15; c = 4'd15; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (p !== 8'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: p=%0d valid=%b busy=%b required p=0 valid=0 busy=0", p, valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector("after_reset", 4, 3, 0);
  endtask

  task automatic test_roundtrip;
    logic [2*W-1:0] rp;
    int lat, bc, bad;
    bad = 0;
    for (int d = 0; d < 16; d++)
      for (int v = 1; v < 16; v++) begin
        run_op(d / v, v, d % v, rp, lat, bc);
        checks++;
        if (rp !== 8'(d) || lat != W) begin
          failures++;
          if (bad++ < 5)
            $display("FAIL roundtrip: D=%0d divisor=%0d p=%0d lat=%0d required p=%0d lat=%0d",
                     d, v, rp, lat, d, W);
        end
      end
  endtask

  task automatic test_back_to_back;
    int n, bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    for (int d = 0; d < 16; d++)
      for (int v = 1; v < 16; v++) begin
        a = W'(d / v); b = W'(v); c = W'(d % v);
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          if (bad++ < 5)
            $display("FAIL b2b_accept: valid=%b busy=%b required valid=0 busy=1", valid, busy);
        end
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        n = 0;
        while (!valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        checks++;
        if (p !== 8'(d) || n != W) begin
          failures++;
          if (bad++ < 5)
            $display("FAIL b2b_roundtrip: D=%0d divisor=%0d p=%0d lat=%0d required p=%0d lat=%0d",
                     d, v, p, n, d, W);
        end
      end
    start = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      test_vector("random", int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignored_restart;
    test_reset_mid;
    test_roundtrip;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_add_par.md
# mul_add_par

Sequential shift-and-add multiply-accumulator that computes `p = a*b + c` over W iterations, one operand bit per clock. It is the inverse datapath of the team's sequential restoring divider. Feeding it the divider's quotient, divisor and remainder reconstructs the original dividend, so it serves both as a standalone multiplier and as the round-trip checker in the calculator datapath.

## Interface
Parameters:
- `W`, default 4: operand width. Must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request; sampled on the rising edge of `clk`.
- `a`, input, W: multiplier (the divider's quotient). Sampled only when a start is accepted.
- `b`, input, W: multiplicand (the divider's divisor). Sampled only when a start is accepted.
- `c`, input, W: addend (the divider's remainder). Sampled only when a start is accepted.
- `p`, output, 2W: result, taken directly from the accumulator register.
- `valid`, output, 1: high when `p` holds a completed result.
- `busy`, output, 1: high while iterating; a start is ignored while `busy` is high.

## Operation
- FSM states: IDLE, ITER, DONE.
- Reset, asynchronous with `rst_n` low:
  - state = IDLE, accumulator = 0, bit counter = W-1.
  - All registered operand copies = 0.
  - Outputs: `p` = 0, `valid` = 0, `busy` = 0.
- IDLE or DONE with `start` high, at the edge:
  - Latch `a` and `b` into internal registers.
  - Accumulator ← zero-extended `c`; counter ← W-1.
  - Go to ITER.
- ITER, each edge:
  - If `a_reg[cnt]` is 1, accumulator ← accumulator + (zero-extended `b_reg` << cnt); otherwise the accumulator holds.
  - If cnt == 0, go to DONE; else cnt ← cnt-1.
  - Bits are scanned MSB first, mirroring the divider's scan order.
- DONE:
  - Hold `p`; `valid` = 1.
  - Remain in DONE until the next accepted start or a reset.
- `start` in ITER is ignored: no restart, and operands are not re-sampled.
- Width rule:
  - All adds are 2W bits wide.
  - The maximum result is (2^W-1)² + (2^W-1) = 2^(2W) - 2^W, so no overflow is possible and no carry out is needed.
- `a` = 0 or `b` = 0: still takes the full W iterations; result = `c`.
- Input changes on `a`, `b` or `c` after the start edge have no effect.
- `p` shows partial sums during ITER. Consumers use `p` only while `valid` = 1.

## Timing
- Start accepted at edge k:
  - Edges k+1 … k+W process bits W-1 … 0.
  - `valid` rises after edge k+W, a latency of W cycles from the accepting edge.
- `busy` = 1 from after edge k through edge k+W. `busy` and `valid` are never high together.
- `valid`, `busy` and the state are registered, so there are no combinational paths from the inputs.
- Back-to-back operation: `start` high while in DONE is accepted at that edge. `valid` falls after that same edge, so a new result can be issued every W+1 cycles.
- Reset asserted mid-ITER: the block returns to the reset values immediately, without waiting for a clock edge. The first start after reset deassertion behaves normally.
- `start` held high continuously: the block restarts at each DONE, so `valid` pulses for 1 cycle every W+1 cycles.

## Structure
- Shared package `calc_pkg` holds:
  - The state typedef (IDLE/ITER/DONE).
  - Localparam `CNT_W` = $clog2(W).
  - Shared with the divider: the calculator operand width constant.
- Single module; no sub-module is required.
- The datapath is one 2W-bit adder plus a shifter. Making it a separate combinational helper is not warranted.

## Test plan
All scenarios use W = 4.
- Basic product: `a`=3, `b`=5, `c`=2 → after 4 cycles `valid`=1, `p`=17. `busy` is high for exactly 4 cycles.
- Maximum values: `a`=15, `b`=15, `c`=15 → `p`=240, no wrap.
- Zero operand: `a`=0, `b`=9, `c`=7 → `p`=7, still 4 cycles of latency. Also `a`=9, `b`=0, `c`=0 → `p`=0.
- Ignored restart and operand stability:
  - Start with `a`=2, `b`=6, `c`=1.
  - Pulse `start` at cycle 2 with `a`=15, and change the inputs mid-run.
  - Required: `p`=13 at the original timing.
- Reset mid-operation: `rst_n` low during ITER → `p`=0, `valid`=0, `busy`=0 immediately. Then `a`=4, `b`=3, `c`=0 → `p`=12.
- Divider round-trip:
  - For all D, divisor in 1..15, apply (q, divisor, r) from the divider model.
  - Required: `p` == D. This is also done back-to-back with `start` issued in DONE.
